// File: rtl/health_manager.sv
// health_manager: tracks player health for the health-bar renderer.
// Hits are applied, then followed by a frame-counted invulnerability window
// with a sprite blink. Heals saturate at MAX_HEALTH. Reaching zero health
// ends the round until game_start is pulsed.
module health_manager #(
  parameter int MAX_HEALTH    = 3,
  parameter int INIT_HEALTH   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       heal,
  output logic [3:0] present_health,
  output logic       invulnerable,
  output logic       blink,
  output logic       hit_ack,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIVE  = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_DEAD   = 2'd3;

  localparam logic [3:0] MAX_H      = 4'(MAX_HEALTH);
  localparam logic [3:0] INIT_H     = 4'(INIT_HEALTH);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [1:0] state;
  logic [7:0] invuln_cnt;
  logic [7:0] blink_cnt;

  // Round state machine. Every output is a flop written alongside the state.
  // A hit in ALIVE reloads the window counter and does not decrement it in
  // the same cycle, so the window spans exactly INVULN_FRAMES later ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      present_health <= INIT_H;
      invulnerable   <= 1'b0;
      blink          <= 1'b0;
      hit_ack        <= 1'b0;
      game_over      <= 1'b0;
      invuln_cnt     <= 8'd0;
      blink_cnt      <= 8'd0;
    end else begin
      hit_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (game_start) begin
            state          <= S_ALIVE;
            present_health <= INIT_H;
          end
        end

        S_ALIVE: begin
          if (game_start) begin
            present_health <= INIT_H;
          end else if (hit) begin
            hit_ack <= 1'b1;
            if (present_health <= 4'd1) begin
              present_health <= 4'd0;
              state          <= S_DEAD;
              game_over      <= 1'b1;
            end else begin
              present_health <= present_health - 4'd1;
              state          <= S_INVULN;
              invulnerable   <= 1'b1;
              invuln_cnt     <= INV_LOAD;
              blink_cnt      <= 8'd0;
              blink          <= 1'b1;
            end
          end else if (heal && (present_health < MAX_H)) begin
            present_health <= present_health + 4'd1;
          end
        end

        S_INVULN: begin
          if (game_start) begin
            state          <= S_ALIVE;
            present_health <= INIT_H;
            invulnerable   <= 1'b0;
            blink          <= 1'b0;
            invuln_cnt     <= 8'd0;
            blink_cnt      <= 8'd0;
          end else begin
            if (heal && (present_health < MAX_H)) begin
              present_health <= present_health + 4'd1;
            end
            if (frame_tick) begin
              if (invuln_cnt <= 8'd1) begin
                state        <= S_ALIVE;
                invulnerable <= 1'b0;
                blink        <= 1'b0;
                invuln_cnt   <= 8'd0;
                blink_cnt    <= 8'd0;
              end else begin
                invuln_cnt <= invuln_cnt - 8'd1;
                if (blink_cnt >= BLINK_LAST) begin
                  blink_cnt <= 8'd0;
                  blink     <= ~blink;
                end else begin
                  blink_cnt <= blink_cnt + 8'd1;
                end
              end
            end
          end
        end

        S_DEAD: begin
          present_health <= 4'd0;
          if (game_start) begin
            state          <= S_ALIVE;
            present_health <= INIT_H;
            game_over      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_health_manager.sv
// tb_health_manager: directed scenarios followed by random stimulus, all
// compared cycle by cycle against a behavioural model of the round rules.
module tb_health_manager;

  localparam int MAX_HEALTH    = 3;
  localparam int INIT_HEALTH   = 3;
  localparam int INVULN_FRAMES = 4;
  localparam int BLINK_FRAMES  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       game_start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic [3:0] present_health;
  logic       invulnerable;
  logic       blink;
  logic       hit_ack;
  logic       game_over;

  int checkCount = 0;
  int errorCount = 0;

  // Model: phase 0=idle 1=alive 2=invulnerable 3=dead, plus health and the
  // number of frame ticks seen since the hit that opened the window.
  int mPhase   = 0;
  int mHealth  = INIT_HEALTH;
  int mElapsed = 0;
  int mAck     = 0;

  health_manager #(
    .MAX_HEALTH   (MAX_HEALTH),
    .INIT_HEALTH  (INIT_HEALTH),
    .INVULN_FRAMES(INVULN_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_start    (game_start),
    .frame_tick    (frame_tick),
    .hit           (hit),
    .heal          (heal),
    .present_health(present_health),
    .invulnerable  (invulnerable),
    .blink         (blink),
    .hit_ack       (hit_ack),
    .game_over     (game_over)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int healed(input int h);
    return (h + 1 > MAX_HEALTH) ? MAX_HEALTH : h + 1;
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  task automatic modelStep(input bit r, input bit gs, input bit tk, input bit ht, input bit hl);
    mAck = 0;
    if (r) begin
      mPhase = 0; mHealth = INIT_HEALTH; mElapsed = 0;
    end else begin
      case (mPhase)
        0: if (gs) begin mPhase = 1; mHealth = INIT_HEALTH; end
        1: begin
          if (gs) mHealth = INIT_HEALTH;
          else if (ht) begin
            mAck = 1;
            mHealth = mHealth - 1;
            if (mHealth == 0) mPhase = 3;
            else begin mPhase = 2; mElapsed = 0; end
          end else if (hl) mHealth = healed(mHealth);
        end
        2: begin
          if (gs) begin mPhase = 1; mHealth = INIT_HEALTH; end
          else begin
            if (hl) mHealth = healed(mHealth);
            if (tk) begin
              mElapsed++;
              if (mElapsed == INVULN_FRAMES) mPhase = 1;
            end
          end
        end
        default: if (gs) begin mPhase = 1; mHealth = INIT_HEALTH; end
      endcase
    end
  endtask

  // Drive one cycle of inputs, step the model, then compare all outputs
  // one time unit after the active edge.
  task automatic applyStimulus(input bit r, input bit gs, input bit tk, input bit ht, input bit hl);
    int expBlink;
    @(negedge clk);
    rst = r; game_start = gs; frame_tick = tk; hit = ht; heal = hl;
    modelStep(r, gs, tk, ht, hl);
    @(posedge clk);
    #1;
    expBlink = (mPhase == 2 && ((mElapsed / BLINK_FRAMES) % 2) == 0) ? 1 : 0;
    checkOutput("health",       int'(present_health), mHealth);
    checkOutput("invulnerable", int'(invulnerable),   (mPhase == 2) ? 1 : 0);
    checkOutput("blink",        int'(blink),          expBlink);
    checkOutput("hit_ack",      int'(hit_ack),        mAck);
    checkOutput("game_over",    int'(game_over),      (mPhase == 3) ? 1 : 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic tickWindow();
    for (int i = 0; i < INVULN_FRAMES; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      idleCycles(1);
    end
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_health", int'(present_health), 3);

    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("start_health", int'(present_health), 3);
    checkOutput("start_over",   int'(game_over), 0);

    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("hit1_health", int'(present_health), 2);
    checkOutput("hit1_ack",    int'(hit_ack), 1);
    checkOutput("hit1_inv",    int'(invulnerable), 1);
    idleCycles(1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("hit_ignored", int'(present_health), 2);
    for (int i = 0; i < INVULN_FRAMES; i++) applyStimulus(0, 0, 1, 0, 0);
    checkOutput("window_exit", int'(invulnerable), 0);
    checkOutput("blink_exit",  int'(blink), 0);

    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    tickWindow();
    applyStimulus(0, 0, 0, 1, 0);
    tickWindow();
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("dead_over", int'(game_over), 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("dead_health", int'(present_health), 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("restart_over", int'(game_over), 0);

    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("heal_sat", int'(present_health), 3);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("heal_invuln", int'(present_health), 3);
    tickWindow();

    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("hit_heal_health", int'(present_health), 2);
    checkOutput("hit_heal_ack",    int'(hit_ack), 1);
    tickWindow();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("mid_health", int'(present_health), 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("rst_health", int'(present_health), 3);
    checkOutput("rst_inv",    int'(invulnerable), 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("idle_hit_ack", int'(hit_ack), 0);

    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("start_beats_hit", int'(hit_ack), 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(199) == 0),
                    ($urandom_range(39) == 0),
                    ($urandom_range(2) == 0),
                    ($urandom_range(6) == 0),
                    ($urandom_range(6) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
